// File: rtl/janela_ctrl_if.sv
// Stream handshakes of the window controller: input word stream and result stream.
// The controller takes the slave side; the producer/consumer takes the master side.
interface janela_ctrl_if;
    logic in_valid;
    logic in_ready;
    logic out_valid;
    logic out_ready;
    logic out_last;

    modport master (
        output in_valid,
        input  in_ready,
        input  out_valid,
        output out_ready,
        input  out_last
    );

    modport slave (
        input  in_valid,
        output in_ready,
        output out_valid,
        input  out_ready,
        output out_last
    );
endinterface

// File: rtl/janela_ctrl.sv
// Sequencer for the window datapath: load N words, run the comparator, capture, stream out.
// Optional PROC watchdog is built only when JANELA_TIMEOUT_EN is defined.
module janela_ctrl #(
    parameter int N       = 9,
    parameter int AW      = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    janela_ctrl_if.slave      bus,
    output logic              mem_in_we,
    output logic [AW-1:0]     mem_in_wa,
    output logic              proc_start,
    input  logic              proc_done,
    output logic              mem_out_we,
    output logic [AW-1:0]     mem_out_ra,
    output logic              busy,
    output logic [15:0]       janelas,
    output logic              erro
);

    typedef enum logic [1:0] {LOAD, PROC, CAPTURE, UNLOAD} state_t;

    localparam logic [AW-1:0] LAST = AW'(N - 1);

    state_t        state, state_n;
    logic [AW-1:0] cnt, cnt_n;
    logic          out_valid_r, out_valid_n;
    logic          proc_start_n;
    logic          win_done;
    logic          timeout_hit;

`ifdef JANELA_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= LOAD;
            cnt         <= '0;
            out_valid_r <= 1'b0;
            proc_start  <= 1'b0;
            janelas     <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            out_valid_r <= out_valid_n;
            proc_start  <= proc_start_n;
            if (win_done)
                janelas <= janelas + 16'd1;
        end
    end

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        out_valid_n   = out_valid_r;
        proc_start_n  = 1'b0;
        win_done      = 1'b0;
        timeout_hit   = 1'b0;
        bus.in_ready  = 1'b0;
        mem_in_we     = 1'b0;
        mem_in_wa     = cnt;
        mem_out_we    = 1'b0;
        mem_out_ra    = '0;
        case (state)
            LOAD: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    mem_in_we = 1'b1;
                    if (cnt == LAST) begin
                        cnt_n        = '0;
                        state_n      = PROC;
                        proc_start_n = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            PROC: begin
                // done is only trusted once the start pulse has been seen by the core
                if (!proc_start && proc_done)
                    state_n = CAPTURE;
`ifdef JANELA_TIMEOUT_EN
                else if (tcnt == TW'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_n     = LOAD;
                    cnt_n       = '0;
                end
`endif
            end
            CAPTURE: begin
                mem_out_we  = 1'b1;
                state_n     = UNLOAD;
                cnt_n       = '0;
                out_valid_n = 1'b0;
            end
            UNLOAD: begin
                if (!out_valid_r) begin
                    out_valid_n = 1'b1;
                end else if (bus.out_ready) begin
                    if (cnt == LAST) begin
                        out_valid_n = 1'b0;
                        cnt_n       = '0;
                        win_done    = 1'b1;
                        state_n     = LOAD;
                    end else begin
                        // prefetch the next word so the registered read keeps 1 word/cycle
                        mem_out_ra = cnt + 1'b1;
                        cnt_n      = cnt + 1'b1;
                    end
                end else begin
                    mem_out_ra = cnt;
                end
            end
            default: state_n = LOAD;
        endcase
        if (flush) begin
            state_n      = LOAD;
            cnt_n        = '0;
            out_valid_n  = 1'b0;
            proc_start_n = 1'b0;
            mem_in_we    = 1'b0;
            mem_out_we   = 1'b0;
            win_done     = 1'b0;
            timeout_hit  = 1'b0;
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.out_last  = out_valid_r && (cnt == LAST);
    assign busy          = (state != LOAD);

`ifdef JANELA_TIMEOUT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tcnt <= '0;
            erro <= 1'b0;
        end else begin
            if (state == PROC && !flush)
                tcnt <= tcnt + 1'b1;
            else
                tcnt <= '0;
            if (timeout_hit)
                erro <= 1'b1;
        end
    end
`else
    // no watchdog: erro is constant low (TIMEOUT is a positive count)
    assign erro = (TIMEOUT < 0);
`endif

endmodule
